chan_mux_rr: RTL and testbench

//  Parametrised N-channel, WIDTH-bit registered selector. Generalises the 2:1 gate-level mux to NCH channels.

---
 rtl/chan_mux_rr.sv | 153 +++++++++++++++
 tb/tb_chan_mux_rr.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_mux_rr.sv
// -----------------------------------------------------------------------------
// chan_mux_rr
//   N-channel, WIDTH-bit registered selector with a one-deep output register.
//   The channel is picked either by the sel input (fixed mode) or by a
//   round-robin arbiter over the valid channels (rr_en=1).
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset; clears all state at once
//   rr_en      in   1 = round-robin mode, 0 = fixed-select mode
//   sel        in   channel index used in fixed mode
//   in_valid   in   per-channel valid, bit i = channel i
//   in_data    in   channel i data at [i*WIDTH +: WIDTH]
//   in_ready   out  per-channel ready, one-hot or zero
//   out_valid  out  output register holds a beat
//   out_data   out  registered data of the held beat
//   out_chan   out  channel index that supplied out_data
//   out_ready  in   downstream accepts the held beat
//
// Handshake: a beat moves on a port in a cycle where valid and ready are both
// high at the rising clock edge. A source holds its valid and data until that
// happens and never waits for ready before raising valid. in_ready is a
// combinational function of in_valid, rr_en, sel, out_ready and registered
// state only.
// -----------------------------------------------------------------------------
module chan_mux_rr #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rr_en,
  input  logic [SELW-1:0]        sel,
  input  logic [NCH-1:0]         in_valid,
  input  logic [NCH*WIDTH-1:0]   in_data,
  output logic [NCH-1:0]         in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [SELW-1:0]        out_chan,
  input  logic                   out_ready
);

  // Registered state
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_chan_q,  out_chan_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  // Arbitration results
  logic             space;
  logic             fx_v;
  logic             rr_v;
  logic [SELW-1:0]  rr_idx;
  logic             grant_v;
  logic [SELW-1:0]  grant_idx;
  logic             grant_in_valid;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;

  // The output register can take a new beat when empty or being drained.
  assign space = ~out_valid_q | out_ready;

  // Fixed mode: an index beyond the last channel grants nothing.
  assign fx_v = (int'(sel) < NCH);

  // Round-robin search in two passes: first the channels at or above ptr,
  // then wrap to the lowest valid channel. The second pass only wins when
  // nothing at or above ptr is valid, so it always lands below ptr.
  always_comb begin
    rr_v   = 1'b0;
    rr_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!rr_v && in_valid[i] && (SELW'(i) >= ptr_q)) begin
        rr_v   = 1'b1;
        rr_idx = SELW'(i);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!rr_v && in_valid[i]) begin
        rr_v   = 1'b1;
        rr_idx = SELW'(i);
      end
    end
  end

  // Mode select. In fixed mode the selected channel is granted whether or
  // not it is valid, so its in_ready can be high while it idles.
  always_comb begin
    if (rr_en) begin
      grant_v   = rr_v;
      grant_idx = rr_idx;
    end else begin
      grant_v   = fx_v;
      grant_idx = fx_v ? sel : '0;
    end
  end

  // Decode the grant into ready, the granted valid and the data mux.
  always_comb begin
    in_ready       = '0;
    grant_in_valid = 1'b0;
    grant_data     = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_v && (grant_idx == SELW'(i))) begin
        in_ready[i]    = space;
        grant_in_valid = in_valid[i];
        grant_data     = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = grant_v & space & grant_in_valid;

  // Next-state logic for the output register and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      // A new beat replaces any beat drained this cycle without a bubble.
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_chan_d  = grant_idx;
      if (rr_en) begin
        ptr_d = (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + SELW'(1);
      end
    end else if (out_ready) begin
      // Drain with nothing behind it: data and channel keep their last value.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_chan_mux_rr.sv
// -----------------------------------------------------------------------------
// tb_chan_mux_rr
//   Bench for chan_mux_rr. Two instances share the stimulus: a 4-channel one
//   and a 3-channel one (non-power-of-two, with an out-of-range sel value).
//   cur selects which instance the model tracks.
// -----------------------------------------------------------------------------
module tb_chan_mux_rr;

  localparam int W    = 32;
  localparam int SELW = 2;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared stimulus
  logic            rr_en;
  logic [SELW-1:0] sel;
  logic [3:0]      in_valid;
  logic [4*W-1:0]  in_data;
  logic            out_ready;

  // 4-channel instance outputs
  logic [3:0]      rdy4;
  logic            ov4;
  logic [W-1:0]    od4;
  logic [SELW-1:0] oc4;

  // 3-channel instance outputs
  logic [2:0]      rdy3;
  logic            ov3;
  logic [W-1:0]    od3;
  logic [SELW-1:0] oc3;

  chan_mux_rr #(.WIDTH(W), .NCH(4), .SELW(SELW)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .rr_en     (rr_en),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (rdy4),
    .out_valid (ov4),
    .out_data  (od4),
    .out_chan  (oc4),
    .out_ready (out_ready)
  );

  chan_mux_rr #(.WIDTH(W), .NCH(3), .SELW(SELW)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .rr_en     (rr_en),
    .sel       (sel),
    .in_valid  (in_valid[2:0]),
    .in_data   (in_data[3*W-1:0]),
    .in_ready  (rdy3),
    .out_valid (ov3),
    .out_data  (od3),
    .out_chan  (oc3),
    .out_ready (out_ready)
  );

  // Observed outputs of the instance under check
  int              cur;
  logic [3:0]      obs_rdy;
  logic            obs_ov;
  logic [W-1:0]    obs_od;
  logic [SELW-1:0] obs_oc;
  assign obs_rdy = (cur == 1) ? {1'b0, rdy3} : rdy4;
  assign obs_ov  = (cur == 1) ? ov3 : ov4;
  assign obs_od  = (cur == 1) ? od3 : od4;
  assign obs_oc  = (cur == 1) ? oc3 : oc4;

  // Scoreboard / model state
  logic [SELW+W-1:0] exp_q[$];
  logic [SELW-1:0]   m_ptr;
  logic              m_ov;
  int                n_chk = 0;
  int                n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ov  = 1'b0;
    m_ptr = '0;
    exp_q.delete();
  endtask

  // Reference grant: round-robin as a modular walk from the pointer.
  task automatic model_grant(output logic gv, output int gi);
    int n;
    int c;
    n  = (cur == 1) ? 3 : 4;
    gv = 1'b0;
    gi = 0;
    if (rr_en) begin
      for (int k = 0; k < n; k++) begin
        c = (int'(m_ptr) + k) % n;
        if (!gv && in_valid[c]) begin
          gv = 1'b1;
          gi = c;
        end
      end
    end else if (int'(sel) < n) begin
      gv = 1'b1;
      gi = int'(sel);
    end
  endtask

  // One clock cycle. Called at a falling edge with inputs already driven;
  // checks outputs, updates the scoreboard, returns at the next falling edge.
  task automatic step();
    logic              gv;
    int                gi;
    int                n;
    logic              space;
    logic              xfer;
    logic [3:0]        exp_rdy;
    logic [SELW+W-1:0] front;
    #1;
    n = (cur == 1) ? 3 : 4;
    model_grant(gv, gi);
    space   = !m_ov || out_ready;
    exp_rdy = (gv && space) ? (4'b0001 << gi) : 4'b0000;
    check("in_ready", obs_rdy, exp_rdy);
    check("out_valid", obs_ov, m_ov);
    if (m_ov) begin
      if (exp_q.size() != 1) begin
        check("exp_q_size", exp_q.size(), 1);
      end else begin
        front = exp_q[0];
        check("out_chan", obs_oc, front[W +: SELW]);
        check("out_data", obs_od, front[W-1:0]);
      end
    end
    xfer = gv && space && in_valid[gi];
    if (m_ov && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (xfer) exp_q.push_back({SELW'(gi), in_data[gi*W +: W]});
    @(posedge clk);
    if (xfer) begin
      m_ov = 1'b1;
      if (rr_en) m_ptr = (gi == n - 1) ? '0 : SELW'(gi + 1);
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic set_data(input logic [W-1:0] base);
    for (int i = 0; i < 4; i++) in_data[i*W +: W] = base + W'(i);
  endtask

  task automatic do_reset(input int which);
    rst_n = 1'b0;
    cur   = which;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    rr_en     = 1'b0;
    sel       = '0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    cur       = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_valid", ov4, 0);
    check("rst_out_data", od4, 0);
    check("rst_out_chan", oc4, 0);
    rst_n = 1'b1;

    // Fixed mode, sel=2, everyone valid
    rr_en     = 1'b0;
    sel       = 2'd2;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    set_data(32'hA0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("fixed_ready", obs_rdy, 4'b0100);
      check("fixed_chan", obs_oc, 2);
      check("fixed_data", obs_od, 32'hA2);
    end

    // Asynchronous reset in the middle of a held beat, away from any edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", ov4, 0);
    check("async_rst_data", od4, 0);
    check("async_rst_chan", oc4, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin fairness from channel 0
    rr_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("rr_chan", obs_oc, k % 4);
      check("rr_data", obs_od, 32'hA0 + (k % 4));
    end

    // Backpressure: channel 1 beat is held for three cycles
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_chan", obs_oc, 1);
      check("bp_data", obs_od, 32'hA1);
      check("bp_ready", obs_rdy, 0);
    end
    out_ready = 1'b1;
    step();
    check("bp_resume_valid", obs_ov, 1);
    check("bp_resume_chan", obs_oc, 2);

    // Out-of-range select on the 3-channel instance
    do_reset(1);
    rr_en    = 1'b0;
    sel      = 2'd3;
    in_valid = 4'b0111;
    set_data(32'hB0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("oor_ready", obs_rdy, 0);
      check("oor_valid", obs_ov, 0);
    end

    // Round-robin skip and wrap on the 3-channel instance
    rr_en    = 1'b1;
    in_valid = 4'b0010;
    step();
    check("skip_ch1", obs_oc, 1);
    in_valid = 4'b0011;
    step();
    check("wrap_ch0", obs_oc, 0);
    step();
    check("next_ch1", obs_oc, 1);
    in_valid = 4'b0100;
    step();
    check("alone_ch2", obs_oc, 2);
    in_valid = 4'b0111;
    step();
    check("ptr_wrap_ch0", obs_oc, 0);
    check("ptr_wrap_data", obs_od, 32'hB0);

    // Random traffic on both instances
    for (int d = 0; d < 2; d++) begin
      do_reset(d);
      for (int k = 0; k < 150; k++) begin
        rr_en     = 1'($urandom_range(0, 3) != 0);
        sel       = SELW'($urandom_range(0, 3));
        in_valid  = 4'($urandom_range(0, 15));
        out_ready = 1'($urandom_range(0, 3) != 0);
        for (int i = 0; i < 4; i++) in_data[i*W +: W] = $urandom;
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
